// File: rtl/instr_aligner.sv
// Instruction aligner: turns a sequential stream of 32-bit fetch words into
// 16/32-bit instructions with PCs, using a 4-halfword FIFO in front of decode.
module instr_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_16_o
);

  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [15:0] push_hw [2];
  logic [2:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;

  logic        head_is_16;
  logic        accept;
  logic        pop;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  base;
  logic [2:0]  src;
  logic [2:0]  slot;

  assign head_is_16    = (hw_q[0][1:0] != 2'b11);
  assign instr_valid_o = !flush_i &&
                         ((count_q >= 3'd1 && head_is_16) ||
                          (count_q >= 3'd2 && !head_is_16));
  assign fetch_ready_o = (count_q <= 3'd2) && !flush_i;
  assign instr_o       = head_is_16 ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign instr_pc_o    = pc_q;
  assign instr_is_16_o = head_is_16;

  // Flush already forces both handshakes low, so any pop in a flush cycle is dropped.
  assign accept = fetch_valid_i && fetch_ready_o;
  assign pop    = instr_valid_o && instr_ready_i;
  assign pop_n  = pop ? (head_is_16 ? 3'd1 : 3'd2) : 3'd0;
  assign push_n = accept ? (drop_q ? 3'd1 : 3'd2) : 3'd0;
  assign base   = count_q - pop_n;

  assign push_hw[0] = drop_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
  assign push_hw[1] = fetch_data_i[31:16];

  // Shift out popped halfwords, then append pushed halfwords at the post-pop tail.
  always_comb begin
    src  = '0;
    slot = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      slot    = 3'(i);
      src     = slot + pop_n;
      hw_d[i] = (src < 3'd4) ? hw_q[src[1:0]] : hw_q[slot[1:0]];
      if (slot >= base && slot < base + push_n) begin
        hw_d[i] = push_hw[slot[0] ^ base[0]];
      end
    end
  end

  always_comb begin
    count_d = count_q - pop_n + push_n;
    pc_d    = pc_q + {28'h0, pop_n, 1'b0};
    drop_d  = accept ? 1'b0 : drop_q;
    if (flush_i) begin
      count_d = '0;
      pc_d    = flush_pc_i & 32'hFFFF_FFFE;
      drop_d  = flush_pc_i[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      pc_q    <= BOOT_ADDR;
      drop_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        hw_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      hw_q    <= hw_d;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: a halfword-queue reference model predicts
// each cycle's handshakes and presented instruction; a monitor compares them.
module tb_instr_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready_o;
  logic [31:0] fetch_data;
  logic        instr_valid_o;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_16_o;

  always #5 clk = ~clk;

  instr_aligner #(.BOOT_ADDR(BOOT)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .flush_pc_i    (flush_pc),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready_o),
    .fetch_data_i  (fetch_data),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_is_16_o (instr_is_16_o)
  );

  typedef struct {
    logic        fr;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is16;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is16;
    int          cyc;
  } got_t;

  exp_t        expq[$];
  got_t        got[$];
  logic [15:0] hwq[$];
  logic [31:0] m_pc;
  logic        m_drop;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    hwq.delete();
    m_pc   = BOOT;
    m_drop = 1'b0;
  endfunction

  // One clock of stimulus; the model predicts what the DUT shows this cycle
  // and then advances to the state after the next rising edge.
  task automatic cycle(input logic fl, input logic [31:0] fpc, input logic fv,
                       input logic [31:0] d, input logic rdy);
    exp_t        e;
    logic [15:0] h0;
    logic        h16;
    @(negedge clk);
    flush       = fl;
    flush_pc    = fpc;
    fetch_valid = fv;
    fetch_data  = d;
    instr_ready = rdy;
    h0      = (hwq.size() > 0) ? hwq[0] : 16'h0;
    h16     = (h0[1:0] != 2'b11);
    e.fr    = !fl && (hwq.size() <= 2);
    e.iv    = !fl && ((hwq.size() >= 1 && h16) || (hwq.size() >= 2 && !h16));
    e.instr = '0;
    if (e.iv) e.instr = h16 ? {16'h0000, h0} : {hwq[1], h0};
    e.pc    = m_pc;
    e.is16  = h16;
    expq.push_back(e);
    if (fl) begin
      hwq.delete();
      m_pc   = fpc & ~32'h1;
      m_drop = fpc[1];
    end else begin
      if (e.iv && rdy) begin
        void'(hwq.pop_front());
        if (!h16) void'(hwq.pop_front());
        m_pc = m_pc + (h16 ? 32'd2 : 32'd4);
      end
      if (fv && e.fr) begin
        if (!m_drop) hwq.push_back(d[15:0]);
        hwq.push_back(d[31:16]);
        m_drop = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    flush       = 1'b0;
    flush_pc    = '0;
    fetch_valid = 1'b0;
    fetch_data  = '0;
    instr_ready = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", instr_valid_o, 32'd0);
    check("reset_ready", fetch_ready_o, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic expect_got(input string name, input int idx, input logic [31:0] instr,
                            input logic [31:0] pc, input logic is16);
    if (got.size() > idx) begin
      check({name, "_instr"}, got[idx].instr, instr);
      check({name, "_pc"}, got[idx].pc, pc);
      check({name, "_is16"}, got[idx].is16, is16);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("fetch_ready", fetch_ready_o, e.fr);
        check("instr_valid", instr_valid_o, e.iv);
        if (e.iv) begin
          check("instr", instr_o, e.instr);
          check("instr_pc", instr_pc_o, e.pc);
          check("is_16", instr_is_16_o, e.is16);
        end
        if (instr_valid_o && instr_ready)
          got.push_back('{instr: instr_o, pc: instr_pc_o, is16: instr_is_16_o, cyc: cyc});
      end
    end
  end

  initial begin : stimulus
    logic fl;
    rst_n = 1'b0;
    do_reset();

    // Two compressed instructions from one word.
    cycle(1'b0, 32'h0, 1'b1, 32'h0001_4501, 1'b1);
    idle(4, 1'b1);
    #3;
    check("t26_count", got.size(), 32'd2);
    expect_got("t26_0", 0, 32'h0000_4501, 32'h0, 1'b1);
    expect_got("t26_1", 1, 32'h0000_0001, 32'h2, 1'b1);

    // 32-bit instruction straddling two words.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 32'h0513_4505, 1'b1);
    idle(3, 1'b1);
    #3;
    check("t27_straddle_valid", instr_valid_o, 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1);
    idle(3, 1'b1);
    #3;
    expect_got("t27_0", 0, 32'h0000_4505, 32'h0, 1'b1);
    expect_got("t27_1", 1, 32'h0000_0513, 32'h2, 1'b0);

    // Back-to-back 32-bit words at full rate.
    do_reset();
    repeat (3) begin
      cycle(1'b0, 32'h0, 1'b1, 32'h0000_0513, 1'b1);
      #3;
      check("t28_ready", fetch_ready_o, 32'd1);
    end
    idle(2, 1'b1);
    #3;
    check("t28_count", got.size(), 32'd3);
    expect_got("t28_0", 0, 32'h0000_0513, 32'h0, 1'b0);
    expect_got("t28_1", 1, 32'h0000_0513, 32'h4, 1'b0);
    expect_got("t28_2", 2, 32'h0000_0513, 32'h8, 1'b0);
    if (got.size() >= 3) check("t28_spacing", got[2].cyc - got[0].cyc, 32'd2);

    // Flush to a halfword-offset target drops the lower halfword.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 32'h4501_4501, 1'b0);
    cycle(1'b1, 32'h0000_0102, 1'b1, 32'hDEAD_BEEF, 1'b1);
    #3;
    check("t29_flush_valid", instr_valid_o, 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 32'h4585_4501, 1'b1);
    idle(3, 1'b1);
    #3;
    check("t29_count", got.size(), 32'd1);
    expect_got("t29_0", 0, 32'h0000_4585, 32'h0000_0102, 1'b1);

    // Backpressure fills the buffer; nothing lost on release.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 32'h4505_4501, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h450D_4509, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b0);
    #3;
    check("t30_full_ready", fetch_ready_o, 32'd0);
    idle(3, 1'b0);
    #3;
    check("t30_hold_instr", instr_o, 32'h0000_4501);
    check("t30_hold_pc", instr_pc_o, 32'h0);
    idle(6, 1'b1);
    #3;
    check("t30_count", got.size(), 32'd4);
    expect_got("t30_0", 0, 32'h0000_4501, 32'h0, 1'b1);
    expect_got("t30_1", 1, 32'h0000_4505, 32'h2, 1'b1);
    expect_got("t30_2", 2, 32'h0000_4509, 32'h4, 1'b1);
    expect_got("t30_3", 3, 32'h0000_450D, 32'h6, 1'b1);

    // Asynchronous reset with three halfwords buffered.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 32'h4505_4501, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h450D_4509, 1'b1);
    idle(1, 1'b0);
    #3;
    check("t31_three_ready", fetch_ready_o, 32'd0);
    check("t31_three_valid", instr_valid_o, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t31_async_valid", instr_valid_o, 32'd0);
    check("t31_async_ready", fetch_ready_o, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    cycle(1'b0, 32'h0, 1'b1, 32'h0001_4501, 1'b1);
    idle(2, 1'b1);
    #3;
    expect_got("t31_boot", 0, 32'h0000_4501, BOOT, 1'b1);

    // Randomised traffic with occasional flushes.
    do_reset();
    repeat (3000) begin
      fl = ($urandom_range(0, 99) < 3);
      cycle(fl, $urandom, $urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 60);
    end
    idle(8, 1'b1);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
